pix_word_stream_wrap: RTL and testbench

- Generalised pixel-group wrapper between packed multi-pixel video words and a one-pixel-per-cycle processing core (edge detect, grayscale, etc.).
- Unpacks PIX_PER_WORD packed pixels, widens each channel to PROC_W bits and serialises them to the core.
- Collects the core's returned pixels, narrows them back to CH_W bits and re-packs them into one output word with a valid strobe.
- Sits between the frame-buffer read path and the VGA output mux.

---
 rtl/pix_word_pkg.sv | 30 +++
 rtl/pix_serializer.sv | 82 ++++++++
 rtl/pix_word_stream_wrap.sv | 91 +++++++++
 tb/tb_pix_word_stream_wrap.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_word_pkg.sv
// Channel indices, packed-word width derivation and channel widen/narrow helpers.
// PIX_WORD_REPLICATE_EN: widening replicates channel MSBs into the low bits instead of zero padding.
package pix_word_pkg;

    localparam int unsigned CH_B   = 0;
    localparam int unsigned CH_G   = 1;
    localparam int unsigned CH_R   = 2;
    localparam int unsigned NUM_CH = 3;

    function automatic int unsigned calc_word_w(input int unsigned ppw, input int unsigned ch_w);
        return ppw * NUM_CH * ch_w;
    endfunction

    // Left-justifies a ch_w-bit channel into proc_w bits; result sits in the low proc_w bits.
    function automatic logic [31:0] widen_ch(input logic [31:0] c, input int unsigned ch_w,
                                             input int unsigned proc_w);
        logic [31:0] w;
        w = c << (proc_w - ch_w);
`ifdef PIX_WORD_REPLICATE_EN
        w = w | (c >> (ch_w - (proc_w - ch_w)));
`endif
        return w;
    endfunction

    function automatic logic [31:0] narrow_ch(input logic [31:0] c, input int unsigned ch_w,
                                              input int unsigned proc_w);
        return c >> (proc_w - ch_w);
    endfunction

endpackage

// File: rtl/pix_serializer.sv
// Captures a packed word and streams its widened pixels one per cycle, lowest pixel first.
module pix_serializer
    import pix_word_pkg::*;
#(
    parameter int PIX_PER_WORD = 2,
    parameter int CH_W         = 6,
    parameter int PROC_W       = 8,
    parameter int WORD_W       = calc_word_w(PIX_PER_WORD, CH_W)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   line_start,
    input  logic [WORD_W-1:0]      in_word,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [3*PROC_W-1:0]    px_out,
    output logic                   px_out_valid
);

    localparam int IDX_W  = $clog2(PIX_PER_WORD);
    localparam int PIX_W  = 3 * CH_W;
    localparam int WPIX_W = 3 * PROC_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_WORD - 1);

    logic [WORD_W-1:0] hold_r;
    logic [IDX_W-1:0]  ser_idx_r;
    logic [IDX_W-1:0]  next_idx_s;
    logic              px_valid_r;
    logic [WPIX_W-1:0] px_out_r;
    logic [WPIX_W-1:0] first_px_s;
    logic [WPIX_W-1:0] next_px_s;
    logic              idle_ready_s;
    logic              accept_s;

    function automatic logic [WPIX_W-1:0] widen_px(input logic [PIX_W-1:0] p);
        logic [WPIX_W-1:0] w;
        w = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w[ch*PROC_W +: PROC_W] = PROC_W'(widen_ch(32'(p[ch*CH_W +: CH_W]), CH_W, PROC_W));
        end
        return w;
    endfunction

    // Handshake decode and the two candidate pixels for the next px_out load.
    always_comb begin
        idle_ready_s = !px_valid_r || (ser_idx_r == LAST_IDX);
        accept_s     = in_valid && (idle_ready_s || line_start);
        next_idx_s   = (ser_idx_r == LAST_IDX) ? '0 : ser_idx_r + IDX_W'(1);
        first_px_s   = widen_px(in_word[0 +: PIX_W]);
        next_px_s    = widen_px(hold_r[int'(next_idx_s)*PIX_W +: PIX_W]);
    end

    // A new word may load on the same edge the previous last pixel leaves, so streaming has no bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_r     <= '0;
            ser_idx_r  <= '0;
            px_valid_r <= 1'b0;
            px_out_r   <= '0;
        end else if (accept_s) begin
            hold_r     <= in_word;
            ser_idx_r  <= '0;
            px_valid_r <= 1'b1;
            px_out_r   <= first_px_s;
        end else if (line_start) begin
            ser_idx_r  <= '0;
            px_valid_r <= 1'b0;
        end else if (px_valid_r && (ser_idx_r != LAST_IDX)) begin
            ser_idx_r  <= next_idx_s;
            px_out_r   <= next_px_s;
        end else begin
            ser_idx_r  <= '0;
            px_valid_r <= 1'b0;
        end
    end

    // line_start flushes this cycle, so the source may hand over a word regardless of state.
    assign in_ready     = idle_ready_s || line_start;
    assign px_out       = px_out_r;
    assign px_out_valid = px_valid_r;

endmodule

// File: rtl/pix_word_stream_wrap.sv
// Packed-word <-> one-pixel-per-cycle wrapper around a pixel processing core.
// PIX_WORD_REPLICATE_EN selects MSB-replicating widening (see pix_word_pkg).
module pix_word_stream_wrap
    import pix_word_pkg::*;
#(
    parameter int PIX_PER_WORD = 2,
    parameter int CH_W         = 6,
    parameter int PROC_W       = 8,
    parameter int WORD_W       = calc_word_w(PIX_PER_WORD, CH_W)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   line_start,
    input  logic [WORD_W-1:0]      in_word,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [3*PROC_W-1:0]    px_out,
    output logic                   px_out_valid,
    input  logic [3*PROC_W-1:0]    px_in,
    input  logic                   px_in_valid,
    output logic [WORD_W-1:0]      out_word,
    output logic                   out_valid
);

    localparam int IDX_W = $clog2(PIX_PER_WORD);
    localparam int PIX_W = 3 * CH_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_WORD - 1);

    logic [WORD_W-1:0] slots_r;
    logic [WORD_W-1:0] assembled_s;
    logic [WORD_W-1:0] out_word_r;
    logic [IDX_W-1:0]  des_idx_r;
    logic              out_valid_r;
    logic [PIX_W-1:0]  narrow_px_s;

    pix_serializer #(
        .PIX_PER_WORD (PIX_PER_WORD),
        .CH_W         (CH_W),
        .PROC_W       (PROC_W),
        .WORD_W       (WORD_W)
    ) u_ser (
        .clk          (clk),
        .reset        (reset),
        .line_start   (line_start),
        .in_word      (in_word),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .px_out       (px_out),
        .px_out_valid (px_out_valid)
    );

    // Narrow the returned pixel and merge it into its slot of the word being assembled.
    always_comb begin
        narrow_px_s = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            narrow_px_s[ch*CH_W +: CH_W] = CH_W'(narrow_ch(32'(px_in[ch*PROC_W +: PROC_W]), CH_W, PROC_W));
        end
        assembled_s = slots_r;
        assembled_s[int'(des_idx_r)*PIX_W +: PIX_W] = narrow_px_s;
    end

    // Deserialiser: a flush discards the partial group and beats a completing last slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slots_r     <= '0;
            des_idx_r   <= '0;
            out_word_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (line_start) begin
            slots_r     <= '0;
            des_idx_r   <= '0;
            out_valid_r <= 1'b0;
        end else if (px_in_valid) begin
            slots_r <= assembled_s;
            if (des_idx_r == LAST_IDX) begin
                des_idx_r   <= '0;
                out_word_r  <= assembled_s;
                out_valid_r <= 1'b1;
            end else begin
                des_idx_r   <= des_idx_r + IDX_W'(1);
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_word  = out_word_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_pix_word_stream_wrap.sv
// Randomised bench with a cycle-indexed reference model and a 1-cycle loopback core.
module tb_pix_word_stream_wrap;

    localparam int PPW    = 2;
    localparam int CH_W   = 6;
    localparam int PROC_W = 8;
    localparam int PAD    = PROC_W - CH_W;
    localparam int PIX_W  = 3 * CH_W;
    localparam int WPIX_W = 3 * PROC_W;
    localparam int WORD_W = PPW * PIX_W;

`ifdef PIX_WORD_REPLICATE_EN
    localparam logic [WPIX_W-1:0] T1_PX0 = 24'hFF0055;
    localparam logic [WPIX_W-1:0] T1_PX1 = 24'h00FFFF;
`else
    localparam logic [WPIX_W-1:0] T1_PX0 = 24'hFC0054;
    localparam logic [WPIX_W-1:0] T1_PX1 = 24'h00FCFC;
`endif

    logic              clk = 1'b0;
    logic              reset, line_start, in_valid, in_ready, px_out_valid, px_in_valid, out_valid;
    logic [WORD_W-1:0] in_word, out_word;
    logic [WPIX_W-1:0] px_out, px_in;

    always #5 clk = ~clk;

    pix_word_stream_wrap #(.PIX_PER_WORD(PPW), .CH_W(CH_W), .PROC_W(PROC_W)) dut (
        .clk(clk), .reset(reset), .line_start(line_start),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .px_out(px_out), .px_out_valid(px_out_valid),
        .px_in(px_in), .px_in_valid(px_in_valid),
        .out_word(out_word), .out_valid(out_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle model t)", tag, got, exp);
        end
    endtask

    // Reference model state: expectations keyed by cycle number.
    longint            t = 0;
    longint            busy_until = 0;
    logic [WPIX_W-1:0] exp_px  [longint];
    logic [WORD_W-1:0] exp_out [longint];
    logic [WORD_W-1:0] exp_word_hold = '0;
    logic [PIX_W-1:0]  coll [$];
    logic [WORD_W-1:0] e2e  [$];
    logic              lb_v = 1'b0;
    logic [WPIX_W-1:0] lb_d = '0;
    logic              last_accept = 1'b0;
    logic              s_pv, s_ov, s_ir;
    logic [WPIX_W-1:0] s_px_out;
    logic [WORD_W-1:0] s_ow;

    function automatic logic [WPIX_W-1:0] m_widen(input logic [PIX_W-1:0] p);
        logic [WPIX_W-1:0] r;
        int c, w;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            c = int'(p >> (ch * CH_W)) % (1 << CH_W);
            w = c * (1 << PAD);
`ifdef PIX_WORD_REPLICATE_EN
            w = w + c / (1 << (CH_W - PAD));
`endif
            r = r | (WPIX_W'(w) << (ch * PROC_W));
        end
        return r;
    endfunction

    function automatic logic [PIX_W-1:0] m_narrow(input logic [WPIX_W-1:0] p);
        logic [PIX_W-1:0] r;
        int v;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            v = int'(p >> (ch * PROC_W)) % (1 << PROC_W);
            r = r | (PIX_W'(v / (1 << PAD)) << (ch * CH_W));
        end
        return r;
    endfunction

    // One clock cycle: check outputs mid-cycle, advance the model, then clock the loopback core.
    task automatic drive_cycle();
        logic exp_ready, acc;
        logic [WORD_W-1:0] packed_w;
        @(negedge clk);
        exp_ready = line_start || (t >= busy_until);
        if (exp_out.exists(t)) exp_word_hold = exp_out[t];
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("px_out_valid", 64'(px_out_valid), 64'(exp_px.exists(t)));
        if (exp_px.exists(t)) check("px_out", 64'(px_out), 64'(exp_px[t]));
        check("out_valid", 64'(out_valid), 64'(exp_out.exists(t)));
        check("out_word", 64'(out_word), 64'(exp_word_hold));
        s_pv = px_out_valid; s_ov = out_valid; s_ir = in_ready; s_px_out = px_out; s_ow = out_word;

        acc = in_valid && exp_ready;
        if (line_start) begin
            for (int k = 1; k <= PPW; k++) if (exp_px.exists(t + k)) exp_px.delete(t + k);
            busy_until = t;
            coll.delete();
            e2e.delete();
        end
        if (acc) begin
            for (int k = 0; k < PPW; k++) exp_px[t + 1 + k] = m_widen(PIX_W'(in_word >> (k * PIX_W)));
            busy_until = t + PPW;
            e2e.push_back(in_word);
        end
        if (!line_start && px_in_valid) begin
            coll.push_back(m_narrow(px_in));
            if (coll.size() == PPW) begin
                packed_w = '0;
                for (int k = 0; k < PPW; k++) packed_w = packed_w | (WORD_W'(coll[k]) << (k * PIX_W));
                exp_out[t + 1] = packed_w;
                coll.delete();
                check("e2e_pending", 64'(e2e.size() != 0), 64'd1);
                if (e2e.size() != 0) check("e2e_data", 64'(packed_w), 64'(e2e.pop_front()));
            end
        end
        last_accept = acc;
        // The core drops whatever it sees during a flush cycle.
        lb_v = px_out_valid && !line_start;
        lb_d = px_out;
        @(posedge clk);
        #1;
        t++;
        px_in_valid = lb_v;
        px_in       = lb_d;
    endtask

    task automatic do_reset();
        reset = 1'b0; line_start = 1'b0; in_valid = 1'b0;
        px_in_valid = 1'b0; px_in = '0; lb_v = 1'b0; last_accept = 1'b0;
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_px_out", 64'(px_out), 64'd0);
        check("rst_px_out_valid", 64'(px_out_valid), 64'd0);
        check("rst_out_word", 64'(out_word), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        exp_px.delete(); exp_out.delete(); coll.delete(); e2e.delete();
        exp_word_hold = '0;
        busy_until = t;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    int n_strobe, n_acc, n_pv;
    logic [WORD_W-1:0] words [8];
    int idx;

    initial begin
        reset = 1'b0; line_start = 1'b0; in_valid = 1'b0; in_word = '0;
        px_in = '0; px_in_valid = 1'b0;
        do_reset();
        drive_cycle();
        drive_cycle();

        // Single word: widened pixels, then loopback strobe at accept+4.
        in_valid = 1'b1; in_word = 36'h03FFFF015;
        drive_cycle();
        in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive_cycle();
            if (i == 1) check("t1_px0", 64'(s_px_out), 64'(T1_PX0));
            if (i == 2) check("t1_px1", 64'(s_px_out), 64'(T1_PX1));
            check("t1_pv", 64'(s_pv), 64'(i <= 2));
            check("t1_oval", 64'(s_ov), 64'(i == 4));
            if (i == 4) check("t1_oword", 64'(s_ow), 64'h03FFFF015);
        end

        // Eight back-to-back words with in_valid held high.
        for (int i = 0; i < 8; i++) words[i] = WORD_W'({$urandom(), $urandom()});
        idx = 0; n_strobe = 0; n_acc = 0; n_pv = 0;
        in_valid = 1'b1; in_word = words[0];
        for (int c = 0; c < 30; c++) begin
            drive_cycle();
            n_strobe += int'(s_ov);
            n_pv += int'(s_pv);
            if (last_accept) begin
                n_acc++;
                idx++;
            end
            if (idx < 8) in_word = words[idx];
            else in_valid = 1'b0;
        end
        check("b2b_accepts", 64'(n_acc), 64'd8);
        check("b2b_pv_cycles", 64'(n_pv), 64'd16);
        check("b2b_strobes", 64'(n_strobe), 64'd8);

        // line_start after only pixel 0 came back: the word is dropped, the next one is intact.
        in_valid = 1'b1; in_word = 36'h123456789;
        drive_cycle();
        in_valid = 1'b0;
        drive_cycle();
        line_start = 1'b1;
        drive_cycle();
        line_start = 1'b0;
        n_strobe = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle();
            n_strobe += int'(s_ov);
        end
        check("ls_no_strobe", 64'(n_strobe), 64'd0);
        in_valid = 1'b1; in_word = 36'h9ABCDEF01;
        drive_cycle();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) drive_cycle();
        check("ls_recover_valid", 64'(s_ov), 64'd1);
        check("ls_recover_word", 64'(s_ow), 64'h9ABCDEF01);

        // Asynchronous reset in the middle of a group.
        in_valid = 1'b1; in_word = 36'hFEDCBA987;
        drive_cycle();
        in_valid = 1'b0;
        drive_cycle();
        do_reset();
        in_valid = 1'b1; in_word = 36'h000000001;
        drive_cycle();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) drive_cycle();
        check("rst_recover_valid", 64'(s_ov), 64'd1);
        check("rst_recover_word", 64'(s_ow), 64'h000000001);

        // Random traffic with occasional flushes; the source holds a word until accepted.
        in_valid = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!in_valid || last_accept) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_word  = WORD_W'({$urandom(), $urandom()});
            end
            line_start = ($urandom_range(0, 29) == 0);
            drive_cycle();
        end
        line_start = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) drive_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
